utils_adder_arb: RTL and testbench

//  Shares one utils_adder_32 between NUM_REQ requesters (PE-array accumulators, address gen).

---
 rtl/utils_pkg.sv | 22 ++
 rtl/utils_adder_32.sv | 14 +
 rtl/utils_rr_arb.sv | 25 ++
 rtl/utils_adder_arb.sv | 162 ++++++++++++++++
 tb/tb_utils_adder_arb.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/utils_pkg.sv
// rtl/utils_pkg.sv - shared types and widths for the shared-adder arbiter
package utils_pkg;

  localparam int ADDER_W     = 32;
  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_TAG_W   = 4;
  localparam int ARB_ID_W    = $clog2(ARB_NUM_REQ);

  typedef struct packed {
    logic [ADDER_W-1:0]   sum;
    logic                 cout;
    logic [ARB_ID_W-1:0]  id;
    logic [ARB_TAG_W-1:0] tag;
    logic                 last;
  } adder_rsp_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HIGH = 1'b1
  } adder_arb_state_e;

endpackage

// File: rtl/utils_adder_32.sv
// rtl/utils_adder_32.sv - 32-bit adder with carry-in and carry-out
module utils_adder_32
  import utils_pkg::*;
(
  input  logic [ADDER_W-1:0] a_i,
  input  logic [ADDER_W-1:0] b_i,
  input  logic               cin_i,
  output logic [ADDER_W-1:0] sum_o,
  output logic               cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{ADDER_W{1'b0}}, cin_i};

endmodule

// File: rtl/utils_rr_arb.sv
// rtl/utils_rr_arb.sv - round-robin grant: first request at or after the pointer, cyclically
module utils_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o
);

  always_comb begin
    int   idx;
    logic found;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/utils_adder_arb.sv
// rtl/utils_adder_arb.sv - round-robin sharing of one 32-bit adder with a registered response
// Define ADDER_ARB_WIDE_EN for locked two-beat 64-bit adds.
module utils_adder_arb
  import utils_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int TAG_W   = ARB_TAG_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*32-1:0]      req_a,
  input  logic [NUM_REQ*32-1:0]      req_b,
  input  logic [NUM_REQ-1:0]         req_cin,
  input  logic [NUM_REQ-1:0]         req_wide,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic [31:0]                rsp_sum,
  output logic                       rsp_cout,
  output logic                       rsp_last
);

  localparam int IDW = $clog2(NUM_REQ);

  adder_rsp_t         rsp_q, rsp_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] req_eff, gnt;
  logic [IDW-1:0]     g;
  logic               can_issue, accept;
  logic [ADDER_W-1:0] a_sel, b_sel, sum;
  logic [TAG_W-1:0]   tag_sel;
  logic               cin_sel, cout, last_sel, adv_ptr;

  assign can_issue = !rsp_valid_q || rsp_ready;

  utils_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req_i (req_eff),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  assign req_ready = gnt & {NUM_REQ{can_issue}};
  assign accept    = |req_ready;

  always_comb begin
    g = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) g = IDW'(i);
    end
  end

  assign a_sel   = req_a[int'(g)*ADDER_W +: ADDER_W];
  assign b_sel   = req_b[int'(g)*ADDER_W +: ADDER_W];
  assign tag_sel = req_tag[int'(g)*TAG_W +: TAG_W];

  utils_adder_32 u_adder (
    .a_i    (a_sel),
    .b_i    (b_sel),
    .cin_i  (cin_sel),
    .sum_o  (sum),
    .cout_o (cout)
  );

`ifdef ADDER_ARB_WIDE_EN
  adder_arb_state_e state_q, state_d;
  logic             carry_q, carry_d;
  logic [IDW-1:0]   lock_q, lock_d;

  // While a 64-bit op is mid-flight only its owner may be granted; its carry chains in.
  always_comb begin
    req_eff  = req_valid;
    cin_sel  = req_cin[g];
    last_sel = !req_wide[g];
    if (state_q == ARB_HIGH) begin
      req_eff  = req_valid & (NUM_REQ'(1) << lock_q);
      cin_sel  = carry_q;
      last_sel = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    lock_d  = lock_q;
    case (state_q)
      ARB_IDLE: begin
        if (accept && req_wide[g]) begin
          state_d = ARB_HIGH;
          carry_d = cout;
          lock_d  = g;
        end
      end
      ARB_HIGH: begin
        if (accept) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      carry_q <= 1'b0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      lock_q  <= lock_d;
    end
  end
`else
  logic unused_wide;
  assign unused_wide = ^req_wide;
  assign req_eff     = req_valid;
  assign cin_sel     = req_cin[g];
  assign last_sel    = 1'b1;
`endif

  assign adv_ptr = last_sel;

  always_comb begin
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      rsp_d.sum   = sum;
      rsp_d.cout  = cout;
      rsp_d.id    = ARB_ID_W'(g);
      rsp_d.tag   = ARB_TAG_W'(tag_sel);
      rsp_d.last  = last_sel;
      rsp_valid_d = 1'b1;
      if (adv_ptr) rr_ptr_d = (g == IDW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_id    = IDW'(rsp_q.id);
  assign rsp_tag   = TAG_W'(rsp_q.tag);
  assign rsp_last  = rsp_q.last;

endmodule

// File: tb/tb_utils_adder_arb.sv
// tb/tb_utils_adder_arb.sv - randomized and directed checks of utils_adder_arb against a behavioural model
module tb_utils_adder_arb;

  localparam int N   = 4;
  localparam int TW  = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_cin, req_wide;
  logic [N*32-1:0] req_a, req_b;
  logic [N*TW-1:0] req_tag;
  logic            rsp_valid, rsp_ready, rsp_cout, rsp_last;
  logic [IDW-1:0]  rsp_id;
  logic [TW-1:0]   rsp_tag;
  logic [31:0]     rsp_sum;

  utils_adder_arb #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_wide  (req_wide),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_last  (rsp_last)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester-side stimulus, held stable until the op is accepted.
  logic          r_v[N];
  logic [31:0]   r_a[N], r_b[N];
  logic          r_c[N], r_w[N];
  logic [TW-1:0] r_t[N];
  int            refill;
  logic          rand_wide;

  // Reference model of the shared adder.
  int          m_ptr, m_lock, m_id;
  logic        m_valid, m_carry, m_cout, m_last;
  logic [31:0] m_sum;
  logic [TW-1:0] m_tag;
  int          issued, drained;

  task automatic new_op(input int i);
    r_a[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    r_b[i] = $urandom;
    r_c[i] = 1'($urandom_range(0, 1));
    r_w[i] = rand_wide ? 1'($urandom_range(0, 1)) : 1'b0;
    r_t[i] = TW'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    m_valid = 1'b0;
    m_ptr   = 0;
    m_lock  = -1;
    m_carry = 1'b0;
    m_sum   = '0;
    m_cout  = 1'b0;
    m_id    = 0;
    m_tag   = '0;
    m_last  = 1'b0;
  endtask

  task automatic step(output int g);
    logic          can, cin, last, adv;
    logic [N-1:0]  exp_rdy;
    logic [32:0]   total;
    int            idx;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = r_v[i];
      req_a[i*32 +: 32]     = r_a[i];
      req_b[i*32 +: 32]     = r_b[i];
      req_cin[i]            = r_c[i];
      req_wide[i]           = r_w[i];
      req_tag[i*TW +: TW]   = r_t[i];
    end
    #1;
    can = !m_valid || rsp_ready;
    g   = -1;
    if (can) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && r_v[idx] && (m_lock < 0 || m_lock == idx)) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? N'(1) << g : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    check("rsp_payload", 64'({rsp_sum, rsp_cout, rsp_id, rsp_tag, rsp_last}),
          64'({m_sum, m_cout, IDW'(m_id), m_tag, m_last}));
    if (rsp_valid && rsp_ready) drained++;
    @(posedge clk);
    if (g >= 0) begin
      cin  = r_c[g];
      last = 1'b1;
      adv  = 1'b1;
`ifdef ADDER_ARB_WIDE_EN
      if (m_lock >= 0) begin
        cin    = m_carry;
        m_lock = -1;
      end else if (r_w[g]) begin
        last   = 1'b0;
        adv    = 1'b0;
        m_lock = g;
      end
`endif
      total   = 33'(r_a[g]) + 33'(r_b[g]) + 33'(cin);
      m_sum   = total[31:0];
      m_cout  = total[32];
      if (!last) m_carry = m_cout;
      m_id    = g;
      m_tag   = r_t[g];
      m_last  = last;
      m_valid = 1'b1;
      issued++;
      if (adv) m_ptr = (g + 1) % N;
      case (refill)
        0: r_v[g] = 1'b0;
        1: new_op(g);
        default: begin
          r_v[g] = 1'($urandom_range(0, 1));
          new_op(g);
        end
      endcase
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    if (refill == 2) begin
      for (int i = 0; i < N; i++) begin
        if (!r_v[i] && i != g) begin
          r_v[i] = 1'($urandom_range(0, 1));
          new_op(i);
        end
      end
    end
    @(negedge clk);
  endtask

  int gg;

  initial begin
    rand_wide = 1'b0;
    refill    = 0;
    rsp_ready = 1'b1;
    issued    = 0;
    drained   = 0;
    for (int i = 0; i < N; i++) begin
      r_v[i] = 1'b0;
      new_op(i);
    end
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; req_wide = '0; req_tag = '0;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();
    check("reset_valid", 64'(rsp_valid), 64'(0));
    check("reset_sum", 64'(rsp_sum), 64'(0));
    check("reset_last", 64'(rsp_last), 64'(0));

    // Single requester, carry out of the top bit.
    r_v[0] = 1'b1; r_a[0] = 32'hFFFF_FFFF; r_b[0] = 32'd1; r_c[0] = 1'b0; r_w[0] = 1'b0;
    step(gg);
    check("t1_sum", 64'(rsp_sum), 64'(0));
    check("t1_cout", 64'(rsp_cout), 64'(1));
    check("t1_id", 64'(rsp_id), 64'(0));
    check("t1_last", 64'(rsp_last), 64'(1));
    step(gg);

    // All requesters valid: strict rotation from 0.
    do_reset();
    refill = 1;
    for (int i = 0; i < N; i++) begin
      r_v[i] = 1'b1;
      new_op(i);
    end
    for (int k = 0; k < 5; k++) begin
      step(gg);
      check("t2_id", 64'(rsp_id), 64'(k % N));
      check("t2_valid", 64'(rsp_valid), 64'(1));
    end

    // Backpressure for three cycles, then drain and issue together.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(gg);
      check("t3_ready_low", 64'(req_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    step(gg);
    check("t3_id_after", 64'(rsp_id), 64'(1));

`ifdef ADDER_ARB_WIDE_EN
    // Two-beat add on requester 2 while requester 1 waits.
    do_reset();
    refill = 0;
    for (int i = 0; i < N; i++) r_v[i] = 1'b0;
    r_v[2] = 1'b1; r_a[2] = 32'hFFFF_FFFF; r_b[2] = 32'd1; r_c[2] = 1'b0; r_w[2] = 1'b1;
    step(gg);
    check("t4_lo_sum", 64'(rsp_sum), 64'(0));
    check("t4_lo_last", 64'(rsp_last), 64'(0));
    check("t4_lo_id", 64'(rsp_id), 64'(2));
    r_v[2] = 1'b1; r_a[2] = 32'd0; r_b[2] = 32'd0; r_c[2] = 1'b0; r_w[2] = 1'b0;
    r_v[1] = 1'b1; new_op(1);
    step(gg);
    check("t4_hi_sum", 64'(rsp_sum), 64'(1));
    check("t4_hi_last", 64'(rsp_last), 64'(1));
    check("t4_hi_id", 64'(rsp_id), 64'(2));
    step(gg);
    check("t4_next_id", 64'(rsp_id), 64'(1));

    // Reset in the middle of a two-beat op.
    do_reset();
    for (int i = 0; i < N; i++) r_v[i] = 1'b0;
    r_v[2] = 1'b1; r_a[2] = 32'h1234_5678; r_b[2] = 32'h1; r_c[2] = 1'b0; r_w[2] = 1'b1;
    step(gg);
`else
    do_reset();
    refill = 0;
    for (int i = 0; i < N; i++) r_v[i] = 1'b0;
    r_v[2] = 1'b1; new_op(2);
    step(gg);
`endif
    do_reset();
    check("t5_valid", 64'(rsp_valid), 64'(0));
    refill = 1;
    for (int i = 0; i < N; i++) begin
      r_v[i] = 1'b1;
      new_op(i);
    end
    step(gg);
    check("t5_first_id", 64'(rsp_id), 64'(0));

    // Random traffic with random backpressure.
    do_reset();
    refill    = 2;
    rand_wide = 1'b1;
    issued    = 0;
    drained   = 0;
    for (int i = 0; i < N; i++) begin
      r_v[i] = 1'($urandom_range(0, 1));
      new_op(i);
    end
    for (int k = 0; k < 600; k++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      step(gg);
    end
    refill    = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) r_v[i] = 1'b0;
    for (int k = 0; k < 3; k++) step(gg);
    check("no_loss_dup", 64'(drained), 64'(issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
